mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register.
- Takes the latched ALU result, store data and control bits, and runs a req/ack handshake to a multi-cycle data memory.
- Stalls the upstream pipeline while an access is outstanding.
- Owns the MEM/WB pipeline register that feeds write-back.

Parameters:
- TIMEOUT, 16: max WAIT cycles without mem_ack_i before the access is aborted (>=1).
- CNT_W, 5: width of the wait counter; must hold TIMEOUT.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  EX/MEM holds a real instruction (0 = bubble).
- ALUResult_i  in  32  address for loads/stores, result for ALU ops.
- RDData_i  in  32  store data.
- RDAddr_i  in  5  destination register.
- RegWrite_i  in  1  instruction writes a register.
- MemToReg_i  in  1  load (write-back takes memory data).
- MemWrite_i  in  1  store.
- stall_o  out  1  hold EX/MEM and earlier stages this cycle.
- mem_req_o  out  1  memory request, registered.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  32  word-aligned byte address.
- mem_wdata_o  out  32  write data.
- mem_ack_i  in  1  memory completes the access this cycle; mem_rdata_i valid.
- mem_rdata_i  in  32  read data.
- valid_o  out  1  MEM/WB holds a valid instruction.
- RegWrite_o  out  1  write-back enable.
- MemToReg_o  out  1  select MemData_o.
- ALUResult_o  out  32  forwarded ALU result.
- MemData_o  out  32  load data.
- RDAddr_o  out  5  destination register.
- bus_err_o  out  1  one-cycle pulse: misaligned or timed-out access.

Behaviour:
- Reset:
  - All outputs and registers clear to 0; state = IDLE; counter = 0.
  - Async: mem_req_o drops immediately, even mid-WAIT.
- memop = valid_i & (MemToReg_i | MemWrite_i). If both MemToReg_i and MemWrite_i are set, the access is a store.
- stall_o is combinational:
  - (IDLE & memop & aligned), or
  - (WAIT & ~mem_ack_i & cnt != TIMEOUT-1).
- IDLE, non-memop:
  - At the next edge MEM/WB loads valid_i, RegWrite_i & valid_i, MemToReg_i, ALUResult_i, RDAddr_i.
  - MemData_o is held. Latency 1 cycle, no stall.
- IDLE, memop with ALUResult_i[1:0] != 0 (misaligned):
  - No request, no stall.
  - Next edge: MEM/WB loads with RegWrite_o = 0 and valid_o = 1; bus_err_o = 1 for one cycle.
- IDLE, aligned memop:
  - Capture address, wdata, we (= MemWrite_i), RDAddr_i, RegWrite_i, MemToReg_i.
  - mem_req_o <= 1; cnt <= 0; state <= WAIT.
  - MEM/WB loads a bubble (valid_o = 0, RegWrite_o = 0).
- WAIT:
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o hold stable until ack.
  - mem_ack_i = 1:
    - mem_req_o <= 0; state <= IDLE.
    - MEM/WB loads the captured control, with MemData_o <= mem_rdata_i on a load (held on a store).
    - stall_o is 0 in the ack cycle, so EX/MEM advances.
    - Minimum memop latency: 2 cycles.
  - No ack and cnt == TIMEOUT-1:
    - Abort: mem_req_o <= 0; state <= IDLE.
    - MEM/WB loads with RegWrite_o = 0 and valid_o = 1; bus_err_o pulses.
    - stall_o is 0 in this cycle.
  - Otherwise cnt <= cnt + 1.
- mem_ack_i in IDLE (late ack after a timeout) is ignored; no state or output change.
- Back-to-back memops: the next request issues the cycle after the ack cycle. mem_req_o is low for at least 1 cycle between accesses.
- ALUResult_o on a memop carries the captured address.

Decomposition:
- Shared package mem_stage_pkg:
  - state enum {ST_IDLE, ST_WAIT};
  - WORD_ALIGN_MASK = 2'b11;
  - register-index width 5; data width 32.
- One sub-module, mem_wb_reg: the MEM/WB register. Load enable, async reset, bubble insert.
- FSM, counter and handshake stay in the top.

Test Plan:
- Bubble and ALU op: valid_i = 0, then an ALU op with ALUResult_i = 0x0000_00A5, RDAddr_i = 3, RegWrite_i = 1 -> valid_o = 0 for the bubble; next cycle RegWrite_o = 1, ALUResult_o = 0xA5, RDAddr_o = 3, stall_o never 1.
- Load, ack after 3 WAIT cycles: addr 0x100, mem_rdata_i = 0xDEADBEEF -> mem_req_o high 3 cycles with mem_we_o = 0 and mem_addr_o = 0x100; stall_o high 3 cycles; then MemData_o = 0xDEADBEEF, MemToReg_o = 1, RegWrite_o = 1.
- Store, immediate ack: addr 0x40, RDData_i = 0x1234 -> one request cycle with mem_we_o = 1 and mem_wdata_o = 0x1234; RegWrite_o = 0; back-to-back load then shows a 1-cycle req gap.
- Misaligned load, addr 0x102 -> mem_req_o stays 0, bus_err_o pulses once, RegWrite_o = 0, no stall.
- Timeout, TIMEOUT = 4, no ack -> mem_req_o high exactly 4 cycles, then bus_err_o pulses and RegWrite_o = 0; a late ack 2 cycles later has no effect.
- Reset mid-WAIT: assert rst_i in the 2nd WAIT cycle -> mem_req_o and stall_o drop in the same cycle and all outputs are 0; a clean load completes after release.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_IDX_W = 5;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  // Control and result fields carried by the MEM/WB register
  typedef struct packed {
    logic                 valid;
    logic                 regWrite;
    logic                 memToReg;
    logic [DATA_W-1:0]    aluResult;
    logic [REG_IDX_W-1:0] rdAddr;
  } wbCtrl_t;

  // True when a byte address lies on a word boundary
  function automatic logic isAligned(input logic [1:0] lowBits);
    return (lowBits & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Request/acknowledge bus between the MEM stage and a multi-cycle data memory.
interface mem_stage_ctrl_if;
  import mem_stage_pkg::*;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );

endinterface

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register with load enable and bubble insertion.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic              bubble,
  input  logic              loadMemData,
  input  wbCtrl_t           ctrlIn,
  input  logic [DATA_W-1:0] memDataIn,
  output wbCtrl_t           ctrlOut,
  output logic [DATA_W-1:0] memDataOut
);

  // Bubble kills only valid and write enable; other fields are don't-care then
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrlOut <= '0;
    end else if (bubble) begin
      ctrlOut.valid    <= 1'b0;
      ctrlOut.regWrite <= 1'b0;
    end else if (load) begin
      ctrlOut <= ctrlIn;
    end
  end

  // Load data changes only when a read completes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      memDataOut <= '0;
    end else if (loadMemData) begin
      memDataOut <= memDataIn;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: issues data-memory accesses, stalls upstream, feeds MEM/WB.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic [DATA_W-1:0]    ALUResult_i,
  input  logic [DATA_W-1:0]    RDData_i,
  input  logic [REG_IDX_W-1:0] RDAddr_i,
  input  logic                 RegWrite_i,
  input  logic                 MemToReg_i,
  input  logic                 MemWrite_i,
  output logic                 stall_o,
  mem_stage_ctrl_if.master     memBus,
  output logic                 valid_o,
  output logic                 RegWrite_o,
  output logic                 MemToReg_o,
  output logic [DATA_W-1:0]    ALUResult_o,
  output logic [DATA_W-1:0]    MemData_o,
  output logic [REG_IDX_W-1:0] RDAddr_o,
  output logic                 bus_err_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t               state, stateNext;
  logic [CNT_W-1:0]     cnt, cntNext;
  logic                 reqNext, busErrNext, capture, stallC;
  logic                 memop, aligned;
  logic                 wbLoad, wbBubble, wbMemLoad;
  wbCtrl_t              wbIn, wbOut;
  logic [REG_IDX_W-1:0] pendRd;
  logic                 pendRegWrite, pendMemToReg;

  assign memop   = valid_i & (MemToReg_i | MemWrite_i);
  assign aligned = isAligned(ALUResult_i[1:0]);

  // Pipeline freeze is forced low while reset is held
  assign stall_o = stallC & ~rst_i;

  // State, wait counter, request and error pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      memBus.mem_req_o <= 1'b0;
      bus_err_o        <= 1'b0;
    end else begin
      state            <= stateNext;
      cnt              <= cntNext;
      memBus.mem_req_o <= reqNext;
      bus_err_o        <= busErrNext;
    end
  end

  // Access parameters latched at issue and held stable until completion
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      memBus.mem_we_o    <= 1'b0;
      memBus.mem_addr_o  <= '0;
      memBus.mem_wdata_o <= '0;
      pendRd             <= '0;
      pendRegWrite       <= 1'b0;
      pendMemToReg       <= 1'b0;
    end else if (capture) begin
      memBus.mem_we_o    <= MemWrite_i;
      memBus.mem_addr_o  <= ALUResult_i;
      memBus.mem_wdata_o <= RDData_i;
      pendRd             <= RDAddr_i;
      pendRegWrite       <= RegWrite_i;
      pendMemToReg       <= MemToReg_i;
    end
  end

  // Next state, stall and MEM/WB load control
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    reqNext    = memBus.mem_req_o;
    busErrNext = 1'b0;
    capture    = 1'b0;
    stallC     = 1'b0;
    wbLoad     = 1'b0;
    wbBubble   = 1'b0;
    wbMemLoad  = 1'b0;
    wbIn       = '{valid: valid_i, regWrite: RegWrite_i & valid_i,
                   memToReg: MemToReg_i, aluResult: ALUResult_i,
                   rdAddr: RDAddr_i};
    case (state)
      ST_IDLE: begin
        if (memop && aligned) begin
          stallC    = 1'b1;
          capture   = 1'b1;
          reqNext   = 1'b1;
          cntNext   = '0;
          stateNext = ST_WAIT;
          wbBubble  = 1'b1;
        end else begin
          wbLoad = 1'b1;
          if (memop) begin
            wbIn.regWrite = 1'b0;
            busErrNext    = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        wbIn = '{valid: 1'b1, regWrite: pendRegWrite, memToReg: pendMemToReg,
                 aluResult: memBus.mem_addr_o, rdAddr: pendRd};
        if (memBus.mem_ack_i) begin
          reqNext   = 1'b0;
          stateNext = ST_IDLE;
          wbLoad    = 1'b1;
          wbMemLoad = ~memBus.mem_we_o;
        end else if (cnt == CNT_LAST) begin
          reqNext       = 1'b0;
          stateNext     = ST_IDLE;
          wbLoad        = 1'b1;
          wbIn.regWrite = 1'b0;
          busErrNext    = 1'b1;
        end else begin
          stallC  = 1'b1;
          cntNext = cnt + CNT_W'(1);
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  mem_wb_reg uMemWb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load        (wbLoad),
    .bubble      (wbBubble),
    .loadMemData (wbMemLoad),
    .ctrlIn      (wbIn),
    .memDataIn   (memBus.mem_rdata_i),
    .ctrlOut     (wbOut),
    .memDataOut  (MemData_o)
  );

  assign valid_o     = wbOut.valid;
  assign RegWrite_o  = wbOut.regWrite;
  assign MemToReg_o  = wbOut.memToReg;
  assign ALUResult_o = wbOut.aluResult;
  assign RDAddr_o    = wbOut.rdAddr;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a transaction-level reference model.
module tb_mem_stage_ctrl;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] ALUResult_i, RDData_i;
  logic [4:0]  RDAddr_i;
  logic        RegWrite_i, MemToReg_i, MemWrite_i;
  logic        stall_o, valid_o, RegWrite_o, MemToReg_o, bus_err_o;
  logic [31:0] ALUResult_o, MemData_o;
  logic [4:0]  RDAddr_o;

  mem_stage_ctrl_if memBus();

  mem_stage_ctrl #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ALUResult_i (ALUResult_i),
    .RDData_i    (RDData_i),
    .RDAddr_i    (RDAddr_i),
    .RegWrite_i  (RegWrite_i),
    .MemToReg_i  (MemToReg_i),
    .MemWrite_i  (MemWrite_i),
    .stall_o     (stall_o),
    .memBus      (memBus),
    .valid_o     (valid_o),
    .RegWrite_o  (RegWrite_o),
    .MemToReg_o  (MemToReg_o),
    .ALUResult_o (ALUResult_o),
    .MemData_o   (MemData_o),
    .RDAddr_o    (RDAddr_o),
    .bus_err_o   (bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  int nCompared = 0;
  int nMismatched = 0;
  int reqCycles = 0, stallCycles = 0, errCycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding access plus the expected MEM/WB contents
  typedef struct {
    logic [31:0] addr;
    logic        isStore;
    logic [4:0]  rd;
    logic        regWrite;
    logic        memToReg;
  } access_t;

  access_t     pend;
  bit          busy;
  int          waits;
  logic        eReq, eWe, eValid, eRegWrite, eMemToReg, eErr;
  logic [31:0] eAddr, eWdata, eAlu, eMemData;
  logic [4:0]  eRd;
  logic        mMemop, mAligned, mStall;

  task automatic modelReset();
    busy = 0; waits = 0;
    eReq = 0; eWe = 0; eAddr = 0; eWdata = 0;
    eValid = 0; eRegWrite = 0; eMemToReg = 0; eAlu = 0; eMemData = 0; eRd = 0; eErr = 0;
  endtask

  // Compare every cycle mid-period, then advance the model to the next edge
  always @(negedge clk_i) begin
    if (rst_i) begin
      check("rst_stall",    32'(stall_o), 32'd0);
      check("rst_req",      32'(memBus.mem_req_o), 32'd0);
      check("rst_we",       32'(memBus.mem_we_o), 32'd0);
      check("rst_addr",     memBus.mem_addr_o, 32'd0);
      check("rst_wdata",    memBus.mem_wdata_o, 32'd0);
      check("rst_valid",    32'(valid_o), 32'd0);
      check("rst_regwrite", 32'(RegWrite_o), 32'd0);
      check("rst_memtoreg", 32'(MemToReg_o), 32'd0);
      check("rst_alu",      ALUResult_o, 32'd0);
      check("rst_memdata",  MemData_o, 32'd0);
      check("rst_rd",       32'(RDAddr_o), 32'd0);
      check("rst_buserr",   32'(bus_err_o), 32'd0);
      modelReset();
    end else begin
      mMemop   = valid_i && (MemToReg_i || MemWrite_i);
      mAligned = (ALUResult_i % 32'd4) == 32'd0;
      mStall   = busy ? (!memBus.mem_ack_i && waits < TO - 1) : (mMemop && mAligned);

      check("stall",    32'(stall_o), 32'(mStall));
      check("mem_req",  32'(memBus.mem_req_o), 32'(eReq));
      if (eReq) begin
        check("mem_we",    32'(memBus.mem_we_o), 32'(eWe));
        check("mem_addr",  memBus.mem_addr_o, eAddr);
        check("mem_wdata", memBus.mem_wdata_o, eWdata);
      end
      check("valid",    32'(valid_o), 32'(eValid));
      check("regwrite", 32'(RegWrite_o), 32'(eRegWrite));
      check("bus_err",  32'(bus_err_o), 32'(eErr));
      check("memdata",  MemData_o, eMemData);
      if (eValid) begin
        check("memtoreg", 32'(MemToReg_o), 32'(eMemToReg));
        check("alu",      ALUResult_o, eAlu);
        check("rd",       32'(RDAddr_o), 32'(eRd));
      end

      if (stall_o) stallCycles++;
      if (memBus.mem_req_o) reqCycles++;
      if (bus_err_o) errCycles++;

      eErr = 1'b0;
      if (!busy) begin
        if (mMemop && mAligned) begin
          busy = 1; waits = 0;
          pend.addr = ALUResult_i; pend.isStore = MemWrite_i; pend.rd = RDAddr_i;
          pend.regWrite = RegWrite_i; pend.memToReg = MemToReg_i;
          eReq = 1; eWe = MemWrite_i; eAddr = ALUResult_i; eWdata = RDData_i;
          eValid = 0; eRegWrite = 0;
        end else begin
          eValid = valid_i; eRegWrite = valid_i && RegWrite_i && !mMemop;
          eMemToReg = MemToReg_i; eAlu = ALUResult_i; eRd = RDAddr_i; eErr = mMemop;
        end
      end else if (memBus.mem_ack_i) begin
        busy = 0; eReq = 0;
        eValid = 1; eRegWrite = pend.regWrite; eMemToReg = pend.memToReg;
        eAlu = pend.addr; eRd = pend.rd;
        if (!pend.isStore) eMemData = memBus.mem_rdata_i;
      end else if (waits == TO - 1) begin
        busy = 0; eReq = 0;
        eValid = 1; eRegWrite = 0; eMemToReg = pend.memToReg;
        eAlu = pend.addr; eRd = pend.rd; eErr = 1;
      end else begin
        waits++;
      end
    end
  end

  task automatic setIn(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic rw, input logic m2r, input logic mw);
    valid_i = v; ALUResult_i = alu; RDData_i = wd; RDAddr_i = rd;
    RegWrite_i = rw; MemToReg_i = m2r; MemWrite_i = mw;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  int s0, r0, e0;

  initial begin
    rst_i = 1'b1;
    setIn(0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    memBus.mem_ack_i = 1'b0;
    memBus.mem_rdata_i = 32'h0;
    tick(); tick();
    rst_i = 1'b0;

    // Bubble followed by an ALU op
    s0 = stallCycles;
    setIn(0, 32'h0, 32'h0, 5'd0, 0, 0, 0); tick();
    check("bubble_valid", 32'(valid_o), 32'd0);
    setIn(1, 32'h0000_00A5, 32'h0, 5'd3, 1, 0, 0); tick();
    check("alu_valid",    32'(valid_o), 32'd1);
    check("alu_regwrite", 32'(RegWrite_o), 32'd1);
    check("alu_result",   ALUResult_o, 32'h0000_00A5);
    check("alu_rd",       32'(RDAddr_o), 32'd3);
    setIn(0, 32'h0, 32'h0, 5'd0, 0, 0, 0); tick();
    check("alu_no_stall", 32'(stallCycles - s0), 32'd0);

    // Load acknowledged in the third WAIT cycle
    s0 = stallCycles; r0 = reqCycles;
    setIn(1, 32'h100, 32'h0, 5'd5, 1, 1, 0);
    tick(); tick(); tick();
    memBus.mem_ack_i = 1'b1; memBus.mem_rdata_i = 32'hDEAD_BEEF; tick();
    memBus.mem_ack_i = 1'b0;
    setIn(0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    check("ld_memdata",  MemData_o, 32'hDEAD_BEEF);
    check("ld_memtoreg", 32'(MemToReg_o), 32'd1);
    check("ld_regwrite", 32'(RegWrite_o), 32'd1);
    check("ld_alu",      ALUResult_o, 32'h100);
    check("ld_req_cyc",  32'(reqCycles - r0), 32'd3);
    check("ld_stall_cyc", 32'(stallCycles - s0), 32'd3);

    // Store with immediate ack, then a back-to-back load
    r0 = reqCycles;
    setIn(1, 32'h40, 32'h1234, 5'd7, 0, 0, 1); tick();
    check("st_we",    32'(memBus.mem_we_o), 32'd1);
    check("st_wdata", memBus.mem_wdata_o, 32'h1234);
    check("st_addr",  memBus.mem_addr_o, 32'h40);
    memBus.mem_ack_i = 1'b1; tick();
    memBus.mem_ack_i = 1'b0;
    check("st_valid",    32'(valid_o), 32'd1);
    check("st_regwrite", 32'(RegWrite_o), 32'd0);
    check("st_memdata_held", MemData_o, 32'hDEAD_BEEF);
    check("st_req_gap",  32'(memBus.mem_req_o), 32'd0);
    check("st_req_cyc",  32'(reqCycles - r0), 32'd1);
    setIn(1, 32'h44, 32'h0, 5'd9, 1, 1, 0); tick();
    check("b2b_req",  32'(memBus.mem_req_o), 32'd1);
    check("b2b_addr", memBus.mem_addr_o, 32'h44);
    memBus.mem_ack_i = 1'b1; memBus.mem_rdata_i = 32'hCAFE_F00D; tick();
    memBus.mem_ack_i = 1'b0;
    setIn(0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    check("b2b_memdata", MemData_o, 32'hCAFE_F00D);
    check("b2b_rd",      32'(RDAddr_o), 32'd9);

    // Misaligned load
    s0 = stallCycles; r0 = reqCycles; e0 = errCycles;
    setIn(1, 32'h102, 32'h0, 5'd4, 1, 1, 0); tick();
    check("mis_err",      32'(bus_err_o), 32'd1);
    check("mis_valid",    32'(valid_o), 32'd1);
    check("mis_regwrite", 32'(RegWrite_o), 32'd0);
    check("mis_req",      32'(memBus.mem_req_o), 32'd0);
    setIn(0, 32'h0, 32'h0, 5'd0, 0, 0, 0); tick();
    check("mis_err_drop",  32'(bus_err_o), 32'd0);
    check("mis_stall_cyc", 32'(stallCycles - s0), 32'd0);
    check("mis_req_cyc",   32'(reqCycles - r0), 32'd0);
    check("mis_err_cyc",   32'(errCycles - e0), 32'd1);

    // Timeout with no ack, then a late ack
    s0 = stallCycles; r0 = reqCycles; e0 = errCycles;
    setIn(1, 32'h200, 32'h0, 5'd6, 1, 1, 0);
    repeat (5) tick();
    setIn(0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    check("to_err",       32'(bus_err_o), 32'd1);
    check("to_valid",     32'(valid_o), 32'd1);
    check("to_regwrite",  32'(RegWrite_o), 32'd0);
    check("to_req",       32'(memBus.mem_req_o), 32'd0);
    check("to_req_cyc",   32'(reqCycles - r0), 32'd4);
    check("to_stall_cyc", 32'(stallCycles - s0), 32'd4);
    tick();
    memBus.mem_ack_i = 1'b1; memBus.mem_rdata_i = 32'h5555_AAAA; #1;
    check("late_stall", 32'(stall_o), 32'd0);
    tick();
    memBus.mem_ack_i = 1'b0;
    check("late_req",     32'(memBus.mem_req_o), 32'd0);
    check("late_memdata", MemData_o, 32'hCAFE_F00D);
    check("late_err_cyc", 32'(errCycles - e0), 32'd1);

    // Reset asserted in the second WAIT cycle, then a clean load
    setIn(1, 32'h300, 32'h0, 5'd2, 1, 1, 0);
    tick(); tick();
    rst_i = 1'b1; #1;
    check("mid_rst_req",     32'(memBus.mem_req_o), 32'd0);
    check("mid_rst_stall",   32'(stall_o), 32'd0);
    check("mid_rst_memdata", MemData_o, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    check("rec_req", 32'(memBus.mem_req_o), 32'd1);
    memBus.mem_ack_i = 1'b1; memBus.mem_rdata_i = 32'h0BAD_F00D; tick();
    memBus.mem_ack_i = 1'b0;
    setIn(0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    check("rec_memdata", MemData_o, 32'h0BAD_F00D);
    check("rec_valid",   32'(valid_o), 32'd1);
    check("rec_rd",      32'(RDAddr_o), 32'd2);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
